// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU/cmd/condition codes, mux select constants.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // flags are {N,Z,C,V}; Cond=1111 falls to the default and never executes
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus the per-instruction condition result, captured
// once in DECODE and used to gate every architectural write of the instruction.
module cond_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_condex,
    input  logic       flag_set,
    input  logic       cv_arith,
    output logic       condex
);

    logic [3:0] flags_reg;
    logic       condex_reg;
    logic       nz_we;
    logic       cv_we;

    assign nz_we  = flag_set & condex_reg;
    assign cv_we  = nz_we & cv_arith;
    assign condex = condex_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg  <= FLAGS_RST;
            condex_reg <= 1'b0;
        end else begin
            if (latch_condex)
                condex_reg <= cond_eval(cond, flags_reg);
            if (nz_we)
                flags_reg[3:2] <= alu_flags[3:2];
            if (cv_we)
                flags_reg[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: instruction-level FSM, ALU decoder,
// and all datapath selects/enables; condition logic lives in cond_unit.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl
);

    state_t     state_reg, state_next;
    logic [1:0] dp_alu_control;
    logic       no_write;
    logic       cv_arith;
    logic       condex;
    logic       latch_condex;
    logic       flag_set;
    logic       dp_write;

    cond_unit #(.FLAGS_RST(FLAGS_RST)) u_cond (
        .clk          (clk),
        .reset        (reset),
        .cond         (Cond),
        .alu_flags    (ALUFlags),
        .latch_condex (latch_condex),
        .flag_set     (flag_set),
        .cv_arith     (cv_arith),
        .condex       (condex)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        dp_alu_control = ALU_ADD;
        no_write       = 1'b1;
        case (Funct[4:1])
            CMD_ADD: begin dp_alu_control = ALU_ADD; no_write = 1'b0; end
            CMD_SUB: begin dp_alu_control = ALU_SUB; no_write = 1'b0; end
            CMD_AND: begin dp_alu_control = ALU_AND; no_write = 1'b0; end
            CMD_ORR: begin dp_alu_control = ALU_ORR; no_write = 1'b0; end
            CMD_CMP: begin dp_alu_control = ALU_SUB; no_write = 1'b1; end
            default: begin dp_alu_control = ALU_ADD; no_write = 1'b1; end
        endcase
    end

    assign cv_arith     = (dp_alu_control == ALU_ADD) || (dp_alu_control == ALU_SUB);
    assign latch_condex = (state_reg == S_DECODE);
    assign flag_set     = ((state_reg == S_EXECR) || (state_reg == S_EXECI)) && Funct[0];
    assign dp_write     = condex & ~no_write;
    assign ImmSrc       = Op;
    assign RegSrc       = {(Op == OP_MEM) && !Funct[0], Op == OP_BR};

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = condex;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = condex;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_reg == S_EXECI) ? SRCB_IMM : SRCB_REG;
                ALUControl = dp_alu_control;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = dp_write;
                PCWrite  = dp_write && (Rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = condex;
            end
            default: state_next = S_FETCH;
        endcase
        // reset overrides every write enable, whatever state is current
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

endmodule
